// File: rtl/fifo_ser_pkg.sv
// fifo_ser_pkg: shared constants and state encodings for the
// FIFO transmit serializer.
package fifo_ser_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_POP    = ST_POP,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/fifo_ser_baud.sv
// fifo_ser_baud: per-bit cycle counter; tick marks the last
// cycle of each serial bit period.
module fifo_ser_baud #(
  parameter int clks_per_bit = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(clks_per_bit * 2);
  localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops FIFO words and sends each as an
// async serial frame (start, LSB-first data, parity, stop).
module fifo_tx_serializer
  import fifo_ser_pkg::*;
#(
  parameter int width        = DEF_WIDTH,
  parameter int clks_per_bit = DEF_CLKS_PER_BIT,
  parameter int parity_en    = 0,
  parameter int parity_odd   = 0,
  parameter int stop_bits    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] fifo_out,
  input  logic             fifo_empty,
  output logic             read_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int IW = $clog2(width + 1);
  // Out-of-range stop counts are pinned to the legal range.
  localparam int STOPS =
    (stop_bits > STOP_BITS_MAX) ? STOP_BITS_MAX :
    (stop_bits < STOP_BITS_MIN) ? STOP_BITS_MIN : stop_bits;
  localparam logic [IW-1:0] LAST_BIT  = IW'(width - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOPS - 1);
  localparam logic          PEN       = (parity_en != 0);
  localparam logic          PODD      = (parity_odd != 0);

  state_t           state_q, state_d;
  logic [width-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             b_clear, b_en, b_tick;

  fifo_ser_baud #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(b_clear),
    .en   (b_en),
    .tick (b_tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    b_clear = 1'b0;
    b_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        b_clear = 1'b1;
        if (!fifo_empty) begin
          rd_d    = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        b_clear = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        b_clear = 1'b1;
        sh_d    = fifo_out;
        tx_d    = 1'b0;
        par_d   = PODD;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        b_en = 1'b1;
        if (b_tick) begin
          tx_d    = sh_q[0];
          par_d   = par_q ^ sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        b_en = 1'b1;
        if (b_tick) begin
          if (idx_q == LAST_BIT) begin
            idx_d = '0;
            if (PEN) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d  = sh_q[0];
            par_d = par_q ^ sh_q[0];
            sh_d  = sh_q >> 1;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        b_en = 1'b1;
        if (b_tick) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        b_en = 1'b1;
        if (b_tick) begin
          if (idx_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign read_en    = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
